// File: rtl/reg_file_pkg.sv
// Shared constants and types for the second-generation register bank.
package reg_file_pkg;

   // Architectural register indices
   localparam int unsigned PC_IDX  = 0;
   localparam int unsigned SP_IDX  = 1;
   localparam int unsigned SR_IDX  = 2;
   localparam int unsigned CG2_IDX = 3;

   // Flag bit positions inside SR
   localparam int unsigned C_BIT = 0;
   localparam int unsigned Z_BIT = 1;
   localparam int unsigned N_BIT = 2;
   localparam int unsigned V_BIT = 8;

   typedef enum logic [0:0] {
      SCRUB,
      RUN
   } state_e;

endpackage

// File: rtl/reg_file_scrub.sv
// Post-reset scrub sequencer: walks every register index once, then enables the bank.
module reg_file_scrub
   import reg_file_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_idx,
   output logic              ready
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // State and scrub counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SCRUB;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: advance the counter while scrubbing, leave after the last index
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_en  = 1'b0;
      ready   = 1'b0;
      unique case (state_q)
         SCRUB: begin
            clr_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
               state_d = RUN;
            end
         end
         RUN: begin
            ready = 1'b1;
         end
         default: begin
            state_d = SCRUB;
         end
      endcase
   end

   assign clr_idx = cnt_q;

endmodule

// File: rtl/reg_file_gen2.sv
// CPU register bank: two registered read ports with write-first bypass, general write
// port, PC load/increment path and SR flag merge, gated by a post-reset scrub.
module reg_file_gen2
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned PC_STEP = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] src_reg,
   input  logic [ADDR_W-1:0] dst_reg,
   input  logic              rd_en,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] pc_out,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_reg,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pc_ld,
   input  logic [DATA_W-1:0] pc_ld_data,
   input  logic              pc_inc,
   input  logic              sr_wr_en,
   input  logic [3:0]        sr_flags,
   output logic              ready
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);
   localparam logic [ADDR_W-1:0] SR_A  = ADDR_W'(SR_IDX);
   localparam logic [ADDR_W-1:0] CG2_A = ADDR_W'(CG2_IDX);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] pc_nxt;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_idx;
   logic              run;

   reg_file_scrub #(
      .ADDR_W (ADDR_W)
   ) u_scrub (
      .clk     (clk),
      .rst     (rst),
      .clr_en  (clr_en),
      .clr_idx (clr_idx),
      .ready   (run)
   );

   // Next value of every register; merges general write, PC path and SR flag path
   always_comb begin
      regs_d = regs_q;
      pc_nxt = regs_q[PC_A];
      if (clr_en) begin
         regs_d[clr_idx] = '0;
      end else if (run) begin
         if (wr_en) begin
            regs_d[wr_reg] = wr_data;
         end
         if (wr_en && (wr_reg == PC_A)) begin
            pc_nxt = wr_data;
         end else if (pc_ld) begin
            pc_nxt = pc_ld_data;
         end else if (pc_inc) begin
            pc_nxt = regs_q[PC_A] + DATA_W'(PC_STEP);
         end
         // PC is always halfword aligned
         regs_d[PC_A] = {pc_nxt[DATA_W-1:1], 1'b0};
         if (!(wr_en && (wr_reg == SR_A)) && sr_wr_en) begin
            regs_d[SR_A][C_BIT] = sr_flags[0];
            regs_d[SR_A][Z_BIT] = sr_flags[1];
            regs_d[SR_A][N_BIT] = sr_flags[2];
            regs_d[SR_A][V_BIT] = sr_flags[3];
         end
         // CG2 is a constant-zero source; writes are discarded
         regs_d[CG2_A] = '0;
      end
   end

   // Read ports capture the post-update value so a same-cycle write is visible
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (run && rd_en) begin
         a_d = regs_d[src_reg];
         b_d = regs_d[dst_reg];
      end
   end

   // Array and read-port registers; only PC needs a reset value, the rest is scrubbed
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q          <= '0;
         b_q          <= '0;
         regs_q[PC_A] <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         regs_q <= regs_d;
      end
   end

   assign a      = a_q;
   assign b      = b_q;
   assign pc_out = regs_q[PC_A];
   assign ready  = run;

endmodule

// File: tb/tb_reg_file_gen2.sv
// Self-checking bench for reg_file_gen2 using an expectation queue per cycle.
module tb_reg_file_gen2;

   localparam int SIG_A   = 0;
   localparam int SIG_B   = 1;
   localparam int SIG_PC  = 2;
   localparam int SIG_RDY = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  src_reg, dst_reg, wr_reg;
   logic        rd_en, wr_en, pc_ld, pc_inc, sr_wr_en;
   logic [15:0] a, b, pc_out, wr_data, pc_ld_data;
   logic [3:0]  sr_flags;
   logic        ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      int          sig;
      logic [15:0] exp;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   reg_file_gen2 dut (
      .clk        (clk),
      .rst        (rst),
      .src_reg    (src_reg),
      .dst_reg    (dst_reg),
      .rd_en      (rd_en),
      .a          (a),
      .b          (b),
      .pc_out     (pc_out),
      .wr_en      (wr_en),
      .wr_reg     (wr_reg),
      .wr_data    (wr_data),
      .pc_ld      (pc_ld),
      .pc_ld_data (pc_ld_data),
      .pc_inc     (pc_inc),
      .sr_wr_en   (sr_wr_en),
      .sr_flags   (sr_flags),
      .ready      (ready)
   );

   function automatic logic [15:0] observe(int sig);
      case (sig)
         SIG_A:   return a;
         SIG_B:   return b;
         SIG_PC:  return pc_out;
         default: return {15'b0, ready};
      endcase
   endfunction

   task automatic push(string name, int sig, logic [15:0] exp);
      exp_t e;
      e.name = name;
      e.sig  = sig;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst        = 1'b0;
      src_reg    = '0;
      dst_reg    = '0;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      wr_reg     = '0;
      wr_data    = '0;
      pc_ld      = 1'b0;
      pc_ld_data = '0;
      pc_inc     = 1'b0;
      sr_wr_en   = 1'b0;
      sr_flags   = '0;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int pass = 0; pass < 2; pass++) begin
         idle();
         rst = 1'b1;
         repeat (3) tick();
         push("reset_ready", SIG_RDY, 16'h0);
         push("reset_a", SIG_A, 16'h0);
         push("reset_b", SIG_B, 16'h0);
         push("reset_pc", SIG_PC, 16'h0);
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s: observed %h expected %h", e.name, observe(e.sig), e.exp);
            end
         end
         rst = 1'b0;
         for (int k = 1; k <= 16; k++) begin
            push("scrub_ready", SIG_RDY, (k == 16) ? 16'h1 : 16'h0);
            tick();
            while (sbq.size() != 0) begin
               e = sbq.pop_front();
               checks++;
               if (observe(e.sig) !== e.exp) begin
                  errors++;
                  $display("FAIL %s (cycle %0d): observed %h expected %h", e.name, k,
                           observe(e.sig), e.exp);
               end
            end
         end
         if (pass == 0) begin
            for (int i = 0; i < 16; i++) begin
               wr_en   = 1'b1;
               wr_reg  = 4'(i);
               wr_data = 16'hFFFF;
               tick();
            end
            wr_en = 1'b0;
         end
      end
      for (int i = 0; i < 16; i++) begin
         rd_en   = 1'b1;
         src_reg = 4'(i);
         dst_reg = 4'(15 - i);
         push("scrubbed_a", SIG_A, 16'h0);
         push("scrubbed_b", SIG_B, 16'h0);
         tick();
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s (index %0d): observed %h expected %h", e.name, i,
                        observe(e.sig), e.exp);
            end
         end
      end
      idle();
   endtask

   task automatic test_write_bypass();
      exp_t e;
      for (int s = 0; s < 3; s++) begin
         idle();
         case (s)
            0: begin
               wr_en = 1'b1; wr_reg = 4'd5; wr_data = 16'h1234;
               rd_en = 1'b1; src_reg = 4'd5; dst_reg = 4'd5;
               push("bypass_a", SIG_A, 16'h1234);
               push("bypass_b", SIG_B, 16'h1234);
            end
            1: begin
               wr_en = 1'b1; wr_reg = 4'd3; wr_data = 16'hBEEF;
               rd_en = 1'b1; src_reg = 4'd3; dst_reg = 4'd5;
               push("cg2_bypass_a", SIG_A, 16'h0);
               push("r5_held_b", SIG_B, 16'h1234);
            end
            default: begin
               rd_en = 1'b1; src_reg = 4'd3; dst_reg = 4'd3;
               push("cg2_read_a", SIG_A, 16'h0);
               push("cg2_read_b", SIG_B, 16'h0);
            end
         endcase
         tick();
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s: observed %h expected %h", e.name, observe(e.sig), e.exp);
            end
         end
      end
      idle();
   endtask

   task automatic test_pc_priority();
      exp_t e;
      for (int s = 0; s < 5; s++) begin
         idle();
         case (s)
            0: begin
               wr_en = 1'b1; wr_reg = 4'd0; wr_data = 16'h0203;
               pc_ld = 1'b1; pc_ld_data = 16'h0100; pc_inc = 1'b1;
               rd_en = 1'b1; src_reg = 4'd0;
               push("pc_wr_wins", SIG_PC, 16'h0202);
               push("pc_wr_bypass_a", SIG_A, 16'h0202);
            end
            1: begin
               pc_inc = 1'b1;
               push("pc_inc", SIG_PC, 16'h0204);
            end
            2: begin
               pc_ld = 1'b1; pc_ld_data = 16'h0101; pc_inc = 1'b1;
               push("pc_ld_over_inc", SIG_PC, 16'h0100);
            end
            3: begin
               pc_ld = 1'b1; pc_ld_data = 16'hFFFE;
               push("pc_ld_top", SIG_PC, 16'hFFFE);
            end
            default: begin
               pc_inc = 1'b1;
               rd_en = 1'b1; src_reg = 4'd0; dst_reg = 4'd0;
               push("pc_wrap", SIG_PC, 16'h0000);
               push("pc_wrap_bypass_b", SIG_B, 16'h0000);
            end
         endcase
         tick();
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s: observed %h expected %h", e.name, observe(e.sig), e.exp);
            end
         end
      end
      idle();
   endtask

   task automatic test_sr_merge();
      exp_t e;
      for (int s = 0; s < 5; s++) begin
         idle();
         rd_en   = 1'b1;
         dst_reg = 4'd2;
         case (s)
            0: begin
               wr_en = 1'b1; wr_reg = 4'd2; wr_data = 16'h0000;
               push("sr_clear", SIG_B, 16'h0000);
            end
            1: begin
               sr_wr_en = 1'b1; sr_flags = 4'b1011;
               push("sr_flags_merge", SIG_B, 16'h0103);
            end
            2: begin
               sr_wr_en = 1'b1; sr_flags = 4'b0100;
               wr_en = 1'b1; wr_reg = 4'd2; wr_data = 16'h00F0;
               push("sr_wr_over_flags", SIG_B, 16'h00F0);
            end
            3: begin
               sr_wr_en = 1'b1; sr_flags = 4'b0100;
               push("sr_keep_other_bits", SIG_B, 16'h00F4);
            end
            default: begin
               sr_wr_en = 1'b1; sr_flags = 4'b0001; src_reg = 4'd2;
               push("sr_carry_only_a", SIG_A, 16'h00F1);
            end
         endcase
         tick();
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s: observed %h expected %h", e.name, observe(e.sig), e.exp);
            end
         end
      end
      idle();
   endtask

   task automatic test_rd_hold();
      exp_t e;
      for (int s = 0; s < 4; s++) begin
         idle();
         src_reg = 4'd4;
         case (s)
            0: begin
               wr_en = 1'b1; wr_reg = 4'd4; wr_data = 16'hAAAA; rd_en = 1'b1;
               push("r4_first_read", SIG_A, 16'hAAAA);
            end
            1: begin
               wr_en = 1'b1; wr_reg = 4'd4; wr_data = 16'h5555;
               push("rd_hold_during_write", SIG_A, 16'hAAAA);
            end
            2: begin
               push("rd_hold_idle", SIG_A, 16'hAAAA);
            end
            default: begin
               rd_en = 1'b1;
               push("r4_reread", SIG_A, 16'h5555);
            end
         endcase
         tick();
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s: observed %h expected %h", e.name, observe(e.sig), e.exp);
            end
         end
      end
      idle();
   endtask

   task automatic test_mid_reset();
      exp_t e;
      for (int s = 0; s < 20; s++) begin
         idle();
         case (s)
            0: begin
               wr_en = 1'b1; wr_reg = 4'd6; wr_data = 16'h6666;
               pc_ld = 1'b1; pc_ld_data = 16'h0010;
               push("pre_reset_pc", SIG_PC, 16'h0010);
            end
            1: begin
               rst = 1'b1; pc_inc = 1'b1;
               push("midrst_pc", SIG_PC, 16'h0000);
               push("midrst_ready", SIG_RDY, 16'h0);
               push("midrst_a", SIG_A, 16'h0000);
            end
            18: begin
               rd_en = 1'b1; src_reg = 4'd6; dst_reg = 4'd2;
               push("post_scrub_r6", SIG_A, 16'h0000);
               push("post_scrub_sr", SIG_B, 16'h0000);
               push("post_scrub_pc", SIG_PC, 16'h0000);
            end
            19: begin
               wr_en = 1'b1; wr_reg = 4'd6; wr_data = 16'h1357;
               rd_en = 1'b1; src_reg = 4'd6;
               push("run_after_scrub", SIG_A, 16'h1357);
            end
            default: begin
               wr_en = 1'b1; wr_reg = 4'd6; wr_data = 16'h7777;
               pc_ld = 1'b1; pc_ld_data = 16'h4444; pc_inc = 1'b1;
               sr_wr_en = 1'b1; sr_flags = 4'hF;
               rd_en = 1'b1; src_reg = 4'd6;
               push("scrub_ready", SIG_RDY, (s == 17) ? 16'h1 : 16'h0);
               push("scrub_pc", SIG_PC, 16'h0000);
               push("scrub_a", SIG_A, 16'h0000);
            end
         endcase
         tick();
         while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if (observe(e.sig) !== e.exp) begin
               errors++;
               $display("FAIL %s (step %0d): observed %h expected %h", e.name, s,
                        observe(e.sig), e.exp);
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_pc_priority();
      test_sr_merge();
      test_rd_hold();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
